// File: rtl/uart_load_ctrl.sv
// ---------------------------------------------------------------------------
// UartLoadCtrl -- serial program loader
//
// Purpose:
//   Receives a program image byte by byte from a UART receiver and writes it
//   into a word-wide memory through port B.  The image starts with a 4-byte
//   little-endian length header (number of 32-bit words N), followed by N
//   payload words, each also sent little-endian.  Every completed word is
//   written with a single one-cycle strobe at BASE_ADDR + 4*index.  When all N
//   words are written, UartOver rises and the CPU is allowed to run.  A bad
//   header or an inter-byte gap longer than TIMEOUT_CYCLES aborts the load
//   and raises LoadError.
//
// Parameters:
//   BASE_ADDR      byte address of the first loaded word
//   MAX_WORDS      largest accepted program length in words (<= 65535)
//   TIMEOUT_CYCLES maximum inter-byte gap in clk cycles
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   Start        one-cycle pulse that begins or restarts a load
//   RxValid      one-cycle pulse presenting RxByte
//   RxByte       received byte
//   UartAddress  byte address for memory port B (held between strobes)
//   UartData     word for memory port B (held between strobes)
//   UartWrite    one-cycle write strobe for port B
//   UartOver     load complete, CPU may run
//   LoadError    load aborted on an error
//   WordsLoaded  number of words written in the current load
// ---------------------------------------------------------------------------
module uart_load_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 16384,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        RxValid,
    input  logic [7:0]  RxByte,
    output logic [31:0] UartAddress,
    output logic [31:0] UartData,
    output logic        UartWrite,
    output logic        UartOver,
    output logic        LoadError,
    output logic [15:0] WordsLoaded
);

    // FSM encoding
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] WRITE   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] ERROR   = 3'd5;

    // The timeout counter only ever holds 0 .. TIMEOUT_CYCLES-1; the cycle
    // that would carry it to TIMEOUT_CYCLES is the one that aborts the load.
    localparam int TimeoutWidth = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [TimeoutWidth-1:0] TimeoutOne  = TimeoutWidth'(1);
    localparam logic [31:0]             MaxLength   = 32'(MAX_WORDS);

    logic [2:0]              state;
    logic [2:0]              nextState;
    logic [1:0]              byteCount;
    logic [31:0]             assembly;
    logic [15:0]             programLength;
    logic [15:0]             wordIndex;
    logic [TimeoutWidth-1:0] timeoutCount;
    logic [31:0]             addressReg;
    logic [31:0]             dataReg;

    logic [31:0] shiftedWord;
    logic [15:0] nextWordIndex;
    logic        lastWord;
    logic        acceptByte;
    logic        fourthByte;
    logic        headerBad;
    logic        timeoutArmed;
    logic        timeoutExpired;

    // Decode what the current cycle means for the datapath.  Bytes are shifted
    // in from the top, so after four bytes the first one sits in bits 7:0,
    // which gives little-endian assembly without any byte-lane muxing.  A byte
    // arriving during WRITE is kept as byte 0 of the following word, unless
    // that WRITE is for the final word, in which case nothing follows it.
    // Start always wins over a byte presented in the same cycle.
    always_comb begin
        shiftedWord    = {RxByte, assembly[31:8]};
        nextWordIndex  = wordIndex + 16'd1;
        lastWord       = (nextWordIndex == programLength);
        acceptByte     = 1'b0;
        fourthByte     = 1'b0;
        headerBad      = 1'b0;
        timeoutArmed   = 1'b0;
        timeoutExpired = 1'b0;

        if (RxValid && !Start) begin
            if (state == HEADER || state == PAYLOAD) begin
                acceptByte = 1'b1;
            end else if (state == WRITE && !lastWord) begin
                acceptByte = 1'b1;
            end
        end

        if (acceptByte && byteCount == 2'd3 && (state == HEADER || state == PAYLOAD)) begin
            fourthByte = 1'b1;
        end

        if (shiftedWord == 32'd0 || shiftedWord > MaxLength) begin
            headerBad = 1'b1;
        end

        // The gap timer runs in PAYLOAD, and in HEADER only once the first
        // header byte has arrived, so a host may take as long as it likes to
        // begin sending after Start.
        if (state == PAYLOAD || (state == HEADER && byteCount != 2'd0)) begin
            timeoutArmed = 1'b1;
        end

        if (timeoutArmed && !acceptByte && !Start && timeoutCount == TimeoutLast) begin
            timeoutExpired = 1'b1;
        end
    end

    // Next-state logic.  Start restarts a load from any state; the idle,
    // finished and aborted states otherwise wait for it.  A timeout never
    // lands in WRITE, so a partially assembled word is never written.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE, ERROR: begin
                nextState = state;
            end
            HEADER: begin
                if (fourthByte) begin
                    nextState = headerBad ? ERROR : PAYLOAD;
                end else if (timeoutExpired) begin
                    nextState = ERROR;
                end
            end
            PAYLOAD: begin
                if (fourthByte) begin
                    nextState = WRITE;
                end else if (timeoutExpired) begin
                    nextState = ERROR;
                end
            end
            WRITE: begin
                nextState = lastWord ? DONE : PAYLOAD;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        if (Start) begin
            nextState = HEADER;
        end
    end

    // State register; reset beats Start and RxValid in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Byte assembly: a shift register plus a count of bytes gathered for the
    // current header or word.  The count wraps to zero on the fourth byte, and
    // a byte kept from a WRITE cycle leaves it at one.
    always_ff @(posedge clk) begin
        if (reset || Start) begin
            byteCount <= 2'd0;
            assembly  <= 32'd0;
        end else if (acceptByte) begin
            assembly  <= shiftedWord;
            byteCount <= fourthByte ? 2'd0 : byteCount + 2'd1;
        end
    end

    // Latch the program length once the header checks out.  The range check
    // guarantees the value fits in 16 bits.
    always_ff @(posedge clk) begin
        if (reset || Start) begin
            programLength <= 16'd0;
        end else if (state == HEADER && fourthByte && !headerBad) begin
            programLength <= shiftedWord[15:0];
        end
    end

    // Word index advances as WRITE is left.  It doubles as the count of words
    // written in this load, which is what WordsLoaded reports.
    always_ff @(posedge clk) begin
        if (reset || Start) begin
            wordIndex <= 16'd0;
        end else if (state == WRITE) begin
            wordIndex <= nextWordIndex;
        end
    end

    // Inter-byte gap timer.  Every accepted byte clears it, and it is held at
    // zero whenever it is not armed so that re-arming always starts fresh.
    always_ff @(posedge clk) begin
        if (reset || Start) begin
            timeoutCount <= '0;
        end else if (acceptByte || !timeoutArmed || timeoutExpired) begin
            timeoutCount <= '0;
        end else begin
            timeoutCount <= timeoutCount + TimeoutOne;
        end
    end

    // Port B address and data are loaded on the fourth payload byte so they
    // are stable for the whole WRITE cycle, and they simply hold afterwards
    // until the next word replaces them.  The address wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            addressReg <= 32'd0;
            dataReg    <= 32'd0;
        end else if (state == PAYLOAD && fourthByte) begin
            addressReg <= BASE_ADDR + {14'd0, wordIndex, 2'b00};
            dataReg    <= shiftedWord;
        end
    end

    // Outputs are forced low while reset is high so that a reset landing in
    // a WRITE or DONE cycle suppresses the strobe and status immediately
    // rather than one edge later.
    always_comb begin
        UartWrite   = (state == WRITE) && !reset;
        UartOver    = (state == DONE)  && !reset;
        LoadError   = (state == ERROR) && !reset;
        UartAddress = reset ? 32'd0 : addressReg;
        UartData    = reset ? 32'd0 : dataReg;
        WordsLoaded = reset ? 16'd0 : wordIndex;
    end

endmodule

// File: doc/uart_load_ctrl.md
UART_LOAD_CTRL -- requirements
Module: uart_load_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 16384, the largest accepted program length in words (at most 65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, the maximum inter-byte gap in clk cycles.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port Start, input, 1, one-cycle pulse that begins or restarts a load.
REQ-007 SHALL have port RxValid, input, 1, one-cycle pulse that presents a received byte.
REQ-008 SHALL have port RxByte, input, 8, received byte, valid when RxValid=1.
REQ-009 SHALL have port UartAddress, output, 32, byte address for memory port B.
REQ-010 SHALL have port UartData, output, 32, word for memory port B.
REQ-011 SHALL have port UartWrite, output, 1, one-cycle write strobe for port B.
REQ-012 SHALL have port UartOver, output, 1, load complete; the CPU runs only while it is 1.
REQ-013 SHALL have port LoadError, output, 1, load aborted on an error.
REQ-014 SHALL have port WordsLoaded, output, 16, number of words written in the current load.

Function
REQ-015 SHALL implement states IDLE, HEADER, PAYLOAD, WRITE, DONE and ERROR.
REQ-016 Start in any state SHALL go to HEADER and clear: byte counter, word index, WordsLoaded, timeout counter, UartOver, LoadError.
REQ-017 Start and RxValid in the same cycle: Start wins and the byte SHALL be discarded.
REQ-018 RxValid in IDLE, DONE or ERROR SHALL be ignored.
REQ-019 HEADER SHALL collect 4 bytes little-endian (first byte = bits 7:0) as length N.
- N==0 or N>MAX_WORDS -> ERROR.
- Otherwise -> PAYLOAD, and N is latched.
REQ-020 PAYLOAD SHALL assemble 4 bytes little-endian per word; on the 4th byte, go to WRITE in the next cycle.
REQ-021 WRITE SHALL last exactly one cycle with:
- UartWrite=1.
- UartAddress=BASE_ADDR+4*index, computed modulo 2^32.
- UartData=the assembled word.
REQ-022 On leaving WRITE, the block SHALL increment index and WordsLoaded, then:
- index==N -> DONE.
- Otherwise -> PAYLOAD.
REQ-023 A RxValid arriving in the WRITE cycle SHALL be kept as byte 0 of the next word.
- If that WRITE was the last word, the byte SHALL be dropped.
REQ-024 UartOver SHALL be 1 exactly while in DONE, starting the cycle after the last strobe.
REQ-025 LoadError SHALL be 1 exactly while in ERROR.
REQ-026 UartAddress and UartData SHALL hold their last strobed values between strobes.
REQ-027 The timeout counter SHALL count only in HEADER and PAYLOAD, and only after the first header byte.
- It SHALL clear on every accepted byte.
- Reaching TIMEOUT_CYCLES SHALL go to ERROR with no further strobe.
- A partially assembled word SHALL never be written.
REQ-028 UartWrite SHALL never be asserted outside WRITE.
REQ-029 At most one strobe SHALL occur per 4 payload bytes.

Reset
REQ-030 While reset is 1, the state SHALL be IDLE and all outputs SHALL be 0 (UartAddress, UartData, UartWrite, UartOver, LoadError, WordsLoaded).
REQ-031 Reset asserted mid-load SHALL abort the load with no strobe that cycle or later; a new Start is needed to load.
REQ-032 Reset SHALL take priority over Start and RxValid in the same cycle.

Verification
REQ-033 Normal load: Start, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> required response:
- Strobe at address 0x0 with data 0x00000013.
- Strobe at address 0x4 with data 0x00100093.
- UartOver=1 one cycle after the 2nd strobe; WordsLoaded=2; LoadError=0.
REQ-034 Bad header: Start, then bytes 00 00 00 00 -> LoadError=1, UartOver=0, no strobe.
REQ-035 Timeout (TIMEOUT_CYCLES=100): header 01 00 00 00, then bytes AA BB, then 100 idle cycles -> ERROR, no strobe, WordsLoaded=0.
REQ-036 Restart: Start mid-payload, then a clean 1-word load of EF BE AD DE -> required response:
- Strobe at address 0x0 with data 0xDEADBEEF.
- UartOver=1.
REQ-037 Byte in WRITE: N=2, and byte 0 of word 2 arrives in the WRITE cycle of word 1 -> word 2 is written correctly at address 0x4.
REQ-038 Reset mid-load: reset asserted after 6 payload bytes -> all outputs 0 next cycle, no strobe, state IDLE.
